// File: rtl/disp_hms_7seg_scan.sv
// rtl/disp_hms_7seg_scan.sv - six-digit HH:MM:SS multiplexed 7-segment scanner with field blink
// Optional: define DISP_COLON_DP_EN to flash the decimal points after HH and MM as a colon.
module disp_hms_7seg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hh_d1,
    input  logic [3:0] hh_d0,
    input  logic [3:0] mm_d1,
    input  logic [3:0] mm_d0,
    input  logic [3:0] ss_d1,
    input  logic [3:0] ss_d0,
    input  logic [1:0] edit_sel,
    input  logic       disp_en,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [RW-1:0] r_ref_cnt;
    logic [2:0]    r_slot;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [1:0]    r_edit_q;

    logic [RW-1:0] w_ref_nxt;
    logic [2:0]    w_slot_nxt;
    logic [BW-1:0] w_blink_nxt;
    logic          w_phase_nxt;
    logic [3:0]    w_digit;
    logic [6:0]    w_dec;
    logic          w_blank;
    logic [6:0]    w_seg_nxt;
    logic [5:0]    w_an_nxt;

    // Outputs are computed from the next counter state so they line up with the counters.
    always_comb begin
        w_ref_nxt  = r_ref_cnt + RW'(1);
        w_slot_nxt = r_slot;
        if (r_ref_cnt == RW'(REFRESH_DIV - 1)) begin
            w_ref_nxt  = '0;
            w_slot_nxt = (r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1;
        end
    end

    always_comb begin
        w_blink_nxt = r_blink_cnt + BW'(1);
        w_phase_nxt = r_blink_phase;
        if (edit_sel != r_edit_q) begin
            w_blink_nxt = '0;
            w_phase_nxt = 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            w_blink_nxt = '0;
            w_phase_nxt = ~r_blink_phase;
        end
    end

    always_comb begin
        case (w_slot_nxt)
            3'd0:    w_digit = ss_d0;
            3'd1:    w_digit = ss_d1;
            3'd2:    w_digit = mm_d0;
            3'd3:    w_digit = mm_d1;
            3'd4:    w_digit = hh_d0;
            default: w_digit = hh_d1;
        endcase
    end

    always_comb begin
        case (w_digit)
            4'd0:    w_dec = 7'b1000000;
            4'd1:    w_dec = 7'b1111001;
            4'd2:    w_dec = 7'b0100100;
            4'd3:    w_dec = 7'b0110000;
            4'd4:    w_dec = 7'b0011001;
            4'd5:    w_dec = 7'b0010010;
            4'd6:    w_dec = 7'b0000010;
            4'd7:    w_dec = 7'b1111000;
            4'd8:    w_dec = 7'b0000000;
            4'd9:    w_dec = 7'b0010000;
            default: w_dec = 7'b1111111;
        endcase
    end

    // Slot pairs {0,1},{2,3},{4,5} are seconds, minutes, hours; edit codes 3,2,1 respectively.
    always_comb begin
        w_blank   = w_phase_nxt && (edit_sel != 2'd0) && (w_slot_nxt[2:1] == 2'd3 - edit_sel);
        w_seg_nxt = w_blank ? 7'b1111111 : w_dec;
        w_an_nxt  = (!disp_en || w_ref_nxt == '0) ? 6'b111111 : ~(6'b000001 << w_slot_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref_cnt     <= '0;
            r_slot        <= 3'd0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_edit_q      <= 2'd0;
            an            <= 6'b111111;
            seg           <= 7'b1111111;
        end else begin
            r_ref_cnt     <= w_ref_nxt;
            r_slot        <= w_slot_nxt;
            r_blink_cnt   <= w_blink_nxt;
            r_blink_phase <= w_phase_nxt;
            r_edit_q      <= edit_sel;
            an            <= w_an_nxt;
            seg           <= w_seg_nxt;
        end
    end

`ifdef DISP_COLON_DP_EN
    logic w_dp_nxt;

    // Colon flashes with the blink phase but ignores edit blanking.
    always_comb begin
        w_dp_nxt = !(disp_en && (w_ref_nxt != '0) && !w_phase_nxt &&
                     (w_slot_nxt == 3'd2 || w_slot_nxt == 3'd4));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp <= 1'b1;
        end else begin
            dp <= w_dp_nxt;
        end
    end
`else
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_disp_hms_7seg_scan.sv
// tb/tb_disp_hms_7seg_scan.sv - self-checking bench for disp_hms_7seg_scan
module tb_disp_hms_7seg_scan;

    localparam int R = 4;
    localparam int B = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] hh_d1, hh_d0, mm_d1, mm_d0, ss_d1, ss_d0;
    logic [1:0] edit_sel;
    logic       disp_en;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    disp_hms_7seg_scan #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk(clk), .reset(reset),
        .hh_d1(hh_d1), .hh_d0(hh_d0), .mm_d1(mm_d1), .mm_d0(mm_d0),
        .ss_d1(ss_d1), .ss_d0(ss_d0),
        .edit_sel(edit_sel), .disp_en(disp_en),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [6:0] seg;
    } dec_vec_t;

    dec_vec_t dv[16];

    int total = 0;
    int bad = 0;

    // Reference model: elapsed clocks since reset and since the last edit change.
    int         m_t;
    int         m_blink;
    logic [1:0] m_edit_q;

    function automatic int m_ref();
        return m_t % R;
    endfunction

    function automatic int m_slot();
        return (m_t / R) % 6;
    endfunction

    function automatic int m_phase();
        return (m_blink / B) % 2;
    endfunction

    task automatic model_reset();
        m_t      = 0;
        m_blink  = 0;
        m_edit_q = 2'd0;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    task automatic expected(output logic [5:0] e_an, output logic [6:0] e_seg, output logic e_dp);
        logic [3:0] dig[6];
        int         s;
        int         ph;
        dig[0] = ss_d0; dig[1] = ss_d1; dig[2] = mm_d0;
        dig[3] = mm_d1; dig[4] = hh_d0; dig[5] = hh_d1;
        s  = m_slot();
        ph = m_phase();
        if (reset) begin
            e_an  = 6'b111111;
            e_seg = 7'b1111111;
            e_dp  = 1'b1;
        end else begin
            e_seg = dv[dig[s]].seg;
            if (ph == 1 && m_edit_q != 2'd0 && (s / 2) == (3 - int'(m_edit_q)))
                e_seg = 7'b1111111;
            e_an = (!disp_en || m_ref() == 0) ? 6'b111111 : ~(6'b000001 << s);
`ifdef DISP_COLON_DP_EN
            e_dp = !(disp_en && m_ref() != 0 && (s == 2 || s == 4) && ph == 0);
`else
            e_dp = 1'b1;
`endif
        end
    endtask

    task automatic tick();
        logic [5:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        @(posedge clk);
        if (!reset) begin
            m_t++;
            if (edit_sel != m_edit_q) begin
                m_blink  = 0;
                m_edit_q = edit_sel;
            end else begin
                m_blink++;
            end
        end
        #1;
        expected(e_an, e_seg, e_dp);
        chk("model_an", {2'b0, an}, {2'b0, e_an});
        chk("model_seg", {1'b0, seg}, {1'b0, e_seg});
        chk("model_dp", {7'b0, dp}, {7'b0, e_dp});
    endtask

    task automatic wait_slot(input int s, input int rf, input string nm);
        int n;
        n = 0;
        while (!(m_slot() == s && m_ref() == rf) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) fail_timeout(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dv[0]  = '{4'd0,  7'b1000000}; dv[1]  = '{4'd1,  7'b1111001};
        dv[2]  = '{4'd2,  7'b0100100}; dv[3]  = '{4'd3,  7'b0110000};
        dv[4]  = '{4'd4,  7'b0011001}; dv[5]  = '{4'd5,  7'b0010010};
        dv[6]  = '{4'd6,  7'b0000010}; dv[7]  = '{4'd7,  7'b1111000};
        dv[8]  = '{4'd8,  7'b0000000}; dv[9]  = '{4'd9,  7'b0010000};
        dv[10] = '{4'd10, 7'b1111111}; dv[11] = '{4'd11, 7'b1111111};
        dv[12] = '{4'd12, 7'b1111111}; dv[13] = '{4'd13, 7'b1111111};
        dv[14] = '{4'd14, 7'b1111111}; dv[15] = '{4'd15, 7'b1111111};

        reset = 1'b1;
        hh_d1 = 4'd1; hh_d0 = 4'd2; mm_d1 = 4'd3; mm_d0 = 4'd4; ss_d1 = 4'd5; ss_d0 = 4'd6;
        edit_sel = 2'd0;
        disp_en  = 1'b1;
        model_reset();

        #12;
        chk("reset_an", {2'b0, an}, 8'h3f);
        chk("reset_seg", {1'b0, seg}, 8'h7f);
        chk("reset_dp", {7'b0, dp}, 8'h01);

        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("first_an", {2'b0, an}, {2'b0, 6'b111110});
        chk("first_seg_6", {1'b0, seg}, {1'b0, 7'b0000010});
        repeat (22) tick();
        wait_slot(5, 2, "wait_slot5");
        chk("slot5_an", {2'b0, an}, {2'b0, 6'b011111});
        chk("slot5_seg_1", {1'b0, seg}, {1'b0, 7'b1111001});

        // Decode table, driven through ss_d0 and checked in slot 0.
        for (int i = 0; i < 16; i++) begin
            ss_d0 = dv[i].d;
            tick();
            wait_slot(0, 1, "wait_decode");
            chk("decode", {1'b0, seg}, {1'b0, dv[i].seg});
        end
        ss_d0 = 4'd6;

        edit_sel = 2'd2;
        repeat (64) tick();

        begin
            int n;
            n = 0;
            while (m_phase() != 1 && n < 40) begin
                tick();
                n++;
            end
            if (n >= 40) fail_timeout("wait_blink");
        end
        edit_sel = 2'd1;
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            if ((m_slot() == 4 || m_slot() == 5) && m_ref() != 0)
                chk("hours_visible", {7'b0, seg == 7'b1111111}, 8'h00);
        end
        repeat (24) tick();

        edit_sel = 2'd0;
        wait_slot(3, 1, "wait_slot3");
        disp_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("disp_off_an", {2'b0, an}, 8'h3f);
        end
        disp_en = 1'b1;
        repeat (8) tick();

        for (int i = 0; i < 300; i++) begin
            hh_d1 = 4'($urandom_range(0, 15)); hh_d0 = 4'($urandom_range(0, 15));
            mm_d1 = 4'($urandom_range(0, 15)); mm_d0 = 4'($urandom_range(0, 15));
            ss_d1 = 4'($urandom_range(0, 15)); ss_d0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) edit_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) disp_en = ~disp_en;
            tick();
        end

        edit_sel = 2'd0;
        disp_en  = 1'b1;
        wait_slot(4, 2, "wait_slot4");
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_an", {2'b0, an}, 8'h3f);
        chk("async_rst_seg", {1'b0, seg}, 8'h7f);
        chk("async_rst_dp", {7'b0, dp}, 8'h01);
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("restart_an", {2'b0, an}, {2'b0, 6'b111110});
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
